// File: rtl/alu_issue_ctrl_if.sv
// alu_issue_ctrl_if: bundles the signals of alu_issue_ctrl that are not
// clock or reset.
//   Command channel  : cmd_valid/cmd_ready handshake carrying cmd_x, cmd_y
//                      and cmd_op.
//   ALU bus          : alu_x, alu_y and alu_opcode drive the ALU; alu_f and
//                      alu_overflow come back from it.
//   Response channel : rsp_valid/rsp_ready handshake carrying rsp_f,
//                      rsp_overflow, rsp_zero and rsp_err.
//   Status           : op_count, the number of completed legal operations.
// Modports: slave is the controller's view; master is the view of the
// environment (command source, ALU and response sink).
`timescale 1ns/1ps
interface alu_issue_ctrl_if #(
  parameter int unsigned CNT_W = 16
) ();
  logic             cmd_valid;
  logic             cmd_ready;
  logic [31:0]      cmd_x;
  logic [31:0]      cmd_y;
  logic [2:0]       cmd_op;

  logic [31:0]      alu_x;
  logic [31:0]      alu_y;
  logic [2:0]       alu_opcode;
  logic [31:0]      alu_f;
  logic             alu_overflow;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [31:0]      rsp_f;
  logic             rsp_overflow;
  logic             rsp_zero;
  logic             rsp_err;

  logic [CNT_W-1:0] op_count;

  modport slave (
    input  cmd_valid, cmd_x, cmd_y, cmd_op,
    input  alu_f, alu_overflow,
    input  rsp_ready,
    output cmd_ready,
    output alu_x, alu_y, alu_opcode,
    output rsp_valid, rsp_f, rsp_overflow, rsp_zero, rsp_err,
    output op_count
  );

  modport master (
    output cmd_valid, cmd_x, cmd_y, cmd_op,
    output alu_f, alu_overflow,
    output rsp_ready,
    input  cmd_ready,
    input  alu_x, alu_y, alu_opcode,
    input  rsp_valid, rsp_f, rsp_overflow, rsp_zero, rsp_err,
    input  op_count
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: sequential front-end for the combinational 32-bit ALU.
// It accepts a command, registers the operands and opcode onto the ALU bus,
// waits SETTLE_CYCLES clocks for the ripple-carry logic to settle, captures
// the result and overflow, derives the zero flag locally, and offers the
// result on a valid/ready response channel. Illegal opcodes (101..111)
// bypass the ALU and return at once with rsp_err set.
// Ports:
//   clk   - single clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - alu_issue_ctrl_if.slave (command, ALU bus, response, op_count)
// Parameters:
//   SETTLE_CYCLES - clocks between driving the ALU and sampling it (1..255)
//   CNT_W         - width of the completed-operation counter
`timescale 1ns/1ps
module alu_issue_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned CNT_W         = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  alu_issue_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // The counter is loaded with SETTLE_CYCLES-1 and sampled at zero, so the
  // result is captured exactly SETTLE_CYCLES edges after the accept edge.
  localparam logic [7:0] LP_SETTLE_M1 = 8'(SETTLE_CYCLES - 1);

  state_t           r_state;
  state_t           w_next;
  logic [7:0]       r_settle;
  logic [31:0]      r_alu_x;
  logic [31:0]      r_alu_y;
  logic [2:0]       r_alu_op;
  logic [31:0]      r_rsp_f;
  logic             r_rsp_ovf;
  logic             r_rsp_zero;
  logic             r_rsp_err;
  logic [CNT_W-1:0] r_op_count;

  logic             w_op_legal;
  logic             w_cmd_ready;
  logic             w_cmd_fire;
  logic             w_settled;
  logic             w_rsp_fire;

  assign w_op_legal = (bus.cmd_op <= 3'd4);

  // Next-state and handshake decode
  always_comb begin
    w_next      = r_state;
    w_cmd_ready = 1'b0;
    w_cmd_fire  = 1'b0;
    w_settled   = 1'b0;
    w_rsp_fire  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_cmd_ready = 1'b1;
        if (bus.cmd_valid) begin
          w_cmd_fire = 1'b1;
          w_next     = w_op_legal ? S_WAIT : S_DONE;
        end
      end
      S_WAIT: begin
        if (r_settle == '0) begin
          w_settled = 1'b1;
          w_next    = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.rsp_ready) begin
          w_rsp_fire = 1'b1;
          w_next     = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // ALU operand bus: only a legal accept updates it, so the last legal
  // operands stay on the bus after completion and across illegal commands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alu_x  <= '0;
      r_alu_y  <= '0;
      r_alu_op <= '0;
    end else if (w_cmd_fire && w_op_legal) begin
      r_alu_x  <= bus.cmd_x;
      r_alu_y  <= bus.cmd_y;
      r_alu_op <= bus.cmd_op;
    end
  end

  // Settle counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_settle <= '0;
    end else if (w_cmd_fire && w_op_legal) begin
      r_settle <= LP_SETTLE_M1;
    end else if (r_state == S_WAIT && !w_settled) begin
      r_settle <= r_settle - 8'd1;
    end
  end

  // Response capture: an illegal accept produces an error response directly;
  // a legal op samples the ALU once the settle window has elapsed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_f    <= '0;
      r_rsp_ovf  <= 1'b0;
      r_rsp_zero <= 1'b0;
      r_rsp_err  <= 1'b0;
    end else if (w_cmd_fire && !w_op_legal) begin
      r_rsp_f    <= '0;
      r_rsp_ovf  <= 1'b0;
      r_rsp_zero <= 1'b0;
      r_rsp_err  <= 1'b1;
    end else if (w_settled) begin
      r_rsp_f    <= bus.alu_f;
      r_rsp_ovf  <= bus.alu_overflow;
      r_rsp_zero <= (bus.alu_f == '0);
      r_rsp_err  <= 1'b0;
    end
  end

  // Completed-operation counter; wraps naturally at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op_count <= '0;
    end else if (w_rsp_fire && !r_rsp_err) begin
      r_op_count <= r_op_count + 1'b1;
    end
  end

  assign bus.cmd_ready    = w_cmd_ready;
  assign bus.alu_x        = r_alu_x;
  assign bus.alu_y        = r_alu_y;
  assign bus.alu_opcode   = r_alu_op;
  assign bus.rsp_valid    = (r_state == S_DONE);
  assign bus.rsp_f        = r_rsp_f;
  assign bus.rsp_overflow = r_rsp_ovf;
  assign bus.rsp_zero     = r_rsp_zero;
  assign bus.rsp_err      = r_rsp_err;
  assign bus.op_count     = r_op_count;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: self-checking bench for alu_issue_ctrl with a
// behavioural ALU attached to the ALU bus and a transaction-level reference
// model of the expected responses, latency, operand bus and counter.
`timescale 1ns/1ps
module tb_alu_issue_ctrl;
  localparam int unsigned SETTLE = 4;
  localparam int unsigned CW     = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int unsigned errors = 0;
  int unsigned checks = 0;

  // Expected-state model
  logic [31:0]   m_ax = '0;
  logic [31:0]   m_ay = '0;
  logic [2:0]    m_aop = '0;
  logic [CW-1:0] m_cnt = '0;

  alu_issue_ctrl_if #(.CNT_W(CW)) bus ();

  alu_issue_ctrl #(.SETTLE_CYCLES(SETTLE), .CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: returns {overflow, f}. Overflow is the carry out of the
  // adder (x+y for ADD, x+~y+1 for SUB/SLT), 0 for OR/AND.
  function automatic logic [32:0] alu_fn(input logic [31:0] x, input logic [31:0] y,
                                         input logic [2:0] op);
    logic [32:0] s;
    case (op)
      3'd0: s = {1'b0, x} + {1'b0, y};
      3'd1: s = {1'b0, x | y};
      3'd2: s = {1'b0, x & y};
      3'd3: s = {1'b0, x} + {1'b0, ~y} + 33'd1;
      3'd4: begin
        s = {1'b0, x} + {1'b0, ~y} + 33'd1;
        s[31:0] = {31'b0, ($signed(x) < $signed(y))};
      end
      default: s = '0;
    endcase
    return s;
  endfunction

  assign {bus.alu_overflow, bus.alu_f} = alu_fn(bus.alu_x, bus.alu_y, bus.alu_opcode);

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one command from IDLE (called at a falling edge), check the operand
  // bus, latency and response, apply bp cycles of backpressure (optionally
  // presenting the next command meanwhile), then complete the handshake.
  task automatic run_op(input logic [31:0] x, input logic [31:0] y, input logic [2:0] op,
                        input int unsigned bp, input bit chain,
                        input logic [31:0] nx, input logic [31:0] ny, input logic [2:0] nop);
    bit          legal;
    logic [32:0] r;
    int unsigned lat;
    logic [35:0] snap;
    bit          stable;
    legal = (op <= 3'd4);
    bus.cmd_valid = 1'b1;
    bus.cmd_x = x;
    bus.cmd_y = y;
    bus.cmd_op = op;
    check("cmd_ready_idle", bus.cmd_ready, 1);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    bus.cmd_x = $urandom;
    bus.cmd_y = $urandom;
    if (legal) begin
      m_ax = x;
      m_ay = y;
      m_aop = op;
    end
    check("alu_x", bus.alu_x, m_ax);
    check("alu_y", bus.alu_y, m_ay);
    check("alu_opcode", bus.alu_opcode, m_aop);
    lat = 0;
    while (!bus.rsp_valid && lat < 300) begin
      @(negedge clk);
      lat++;
    end
    check("latency", lat, legal ? SETTLE : 0);
    r = legal ? alu_fn(x, y, op) : 33'd0;
    check("rsp_f", bus.rsp_f, r[31:0]);
    check("rsp_overflow", bus.rsp_overflow, r[32]);
    check("rsp_zero", bus.rsp_zero, legal && (r[31:0] == 32'd0));
    check("rsp_err", bus.rsp_err, !legal);
    check("cmd_ready_done", bus.cmd_ready, 0);
    snap = {bus.rsp_f, bus.rsp_overflow, bus.rsp_zero, bus.rsp_err, bus.rsp_valid};
    stable = 1'b1;
    if (chain) begin
      bus.cmd_valid = 1'b1;
      bus.cmd_x = nx;
      bus.cmd_y = ny;
      bus.cmd_op = nop;
    end
    repeat (bp) begin
      @(negedge clk);
      if (snap !== {bus.rsp_f, bus.rsp_overflow, bus.rsp_zero, bus.rsp_err, bus.rsp_valid}
          || bus.cmd_ready !== 1'b0 || bus.alu_x !== m_ax || bus.alu_opcode !== m_aop)
        stable = 1'b0;
    end
    if (bp > 0) check("backpressure_stable", stable, 1);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    if (legal) m_cnt = m_cnt + 1'b1;
    check("rsp_valid_after_hs", bus.rsp_valid, 0);
    check("op_count", bus.op_count, m_cnt);
    check("cmd_ready_after_hs", bus.cmd_ready, 1);
  endtask

  initial begin
    logic [31:0] cx, cy, nx, ny;
    logic [2:0]  cop, nop;
    bit          chain;
    bus.cmd_valid = 1'b0;
    bus.cmd_x = '0;
    bus.cmd_y = '0;
    bus.cmd_op = '0;
    bus.rsp_ready = 1'b0;

    // Reset state
    #3;
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_alu_x", bus.alu_x, 0);
    check("rst_alu_opcode", bus.alu_opcode, 0);
    check("rst_rsp_f", bus.rsp_f, 0);
    check("rst_rsp_err", bus.rsp_err, 0);
    check("rst_op_count", bus.op_count, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases
    run_op(32'd2, 32'd3, 3'b000, 0, 0, '0, '0, '0);
    run_op(32'd1, 32'd7, 3'b000, 0, 0, '0, '0, '0);
    run_op(32'd5, 32'd5, 3'b011, 0, 0, '0, '0, '0);
    run_op(32'hF0, 32'h0F, 3'b001, 0, 0, '0, '0, '0);
    run_op(32'hFFFF_FFFF, 32'd1, 3'b000, 0, 0, '0, '0, '0);
    run_op(32'd9, 32'd9, 3'b101, 0, 0, '0, '0, '0);
    run_op(32'd3, 32'd8, 3'b100, 0, 0, '0, '0, '0);
    run_op(32'hAA55, 32'h0FF0, 3'b010, 0, 0, '0, '0, '0);

    // Backpressure with a waiting command, then its acceptance
    run_op(32'd10, 32'd20, 3'b000, 10, 1, 32'd30, 32'd40, 3'b011);
    run_op(32'd30, 32'd40, 3'b011, 0, 0, '0, '0, '0);

    // Reset mid-WAIT with the settle counter at 2
    bus.cmd_valid = 1'b1;
    bus.cmd_x = 32'd77;
    bus.cmd_y = 32'd11;
    bus.cmd_op = 3'b000;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    bus.cmd_valid = 1'b1;
    #1;
    m_ax = '0;
    m_ay = '0;
    m_aop = '0;
    m_cnt = '0;
    check("midrst_rsp_valid", bus.rsp_valid, 0);
    check("midrst_alu_x", bus.alu_x, 0);
    check("midrst_alu_y", bus.alu_y, 0);
    check("midrst_op_count", bus.op_count, 0);
    @(negedge clk);
    @(negedge clk);
    check("midrst_no_accept", bus.alu_x, 0);
    bus.cmd_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_rsp_valid_after", bus.rsp_valid, 0);
    run_op(32'd100, 32'd23, 3'b011, 0, 0, '0, '0, '0);

    // Randomized sequence (long enough to wrap the counter)
    cx = $urandom;
    cy = $urandom;
    cop = 3'($urandom_range(0, 7));
    for (int i = 0; i < 40; i++) begin
      nx = $urandom;
      ny = ($urandom_range(0, 3) == 0) ? nx : $urandom;
      nop = 3'($urandom_range(0, 7));
      chain = ($urandom_range(0, 1) == 1);
      run_op(cx, cy, cop, $urandom_range(0, 3), chain, nx, ny, nop);
      if (!chain) begin
        repeat ($urandom_range(0, 2)) begin
          bus.rsp_ready = 1'($urandom);
          @(negedge clk);
        end
        bus.rsp_ready = 1'b0;
        check("idle_alu_hold", bus.alu_x, m_ax);
        check("idle_rsp_valid", bus.rsp_valid, 0);
      end
      cx = nx;
      cy = ny;
      cop = nop;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
Sequential front-end that initiates operations on the team's combinational 32-bit ALU (ops ADD/OR/AND/SUB/SLT).
- Accepts commands over a valid/ready interface and registers operands and opcode onto the ALU input bus.
- Waits a fixed settle window for the ripple-carry logic, then captures f/overflow.
- Derives the zero flag locally, because the ALU ties its zero output low.
- Returns the result over a valid/ready response interface and counts completed operations.

Parameters:
SETTLE_CYCLES, 16, clock cycles between driving ALU inputs and sampling ALU outputs; legal range 1..255; SETTLE_CYCLES x clock period must be at least the ALU worst-case SUB/SLT path delay.
CNT_W, 16, width of the completed-operation counter.

Ports:
clk  in  1  single clock, rising edge.
rst_n  in  1  reset, asynchronous assert, active-low.
cmd_valid  in  1  command present.
cmd_ready  out  1  controller can accept a command.
cmd_x  in  32  operand x.
cmd_y  in  32  operand y.
cmd_op  in  3  opcode: 000 ADD, 001 OR, 010 AND, 011 SUB, 100 SLT; 101-111 illegal.
alu_x  out  32  registered operand to ALU x.
alu_y  out  32  registered operand to ALU y.
alu_opcode  out  3  registered opcode to ALU.
alu_f  in  32  ALU result.
alu_overflow  in  1  ALU overflow (0 for OR/AND).
rsp_valid  out  1  response present.
rsp_ready  in  1  consumer accepts response.
rsp_f  out  32  captured result.
rsp_overflow  out  1  captured overflow.
rsp_zero  out  1  1 when rsp_f == 0 on a legal op.
rsp_err  out  1  illegal opcode flag.
op_count  out  CNT_W  number of legal responses handed off.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to IDLE.
  - alu_x, alu_y, alu_opcode, rsp_f, rsp_overflow, rsp_zero, rsp_err, rsp_valid, settle counter and op_count all go to 0.
  - Any in-flight operation is discarded, with no response.
  - No command is accepted while rst_n is low.
- cmd_ready = (state == IDLE), combinational. rsp_valid = (state == DONE), registered state.
- IDLE:
  - On cmd_valid && cmd_ready with a legal op, at the same edge (E0): load alu_x/alu_y/alu_opcode from cmd_*, load counter with SETTLE_CYCLES-1, go to WAIT.
  - On an illegal op, at E0: alu_* stay unchanged, rsp_f=0, rsp_overflow=0, rsp_zero=0, rsp_err=1, go to DONE.
- WAIT:
  - alu_* held constant.
  - If counter == 0: at that edge capture rsp_f=alu_f, rsp_overflow=alu_overflow, rsp_zero=(alu_f==0), rsp_err=0, go to DONE.
  - Otherwise decrement the counter.
- Latency:
  - Legal op: rsp_valid rises after edge E0+SETTLE_CYCLES.
  - Illegal op: rsp_valid rises after edge E0.
- DONE:
  - rsp_* held stable while rsp_ready is low; no limit on backpressure duration.
  - On rsp_ready high: go to IDLE; if rsp_err == 0, op_count += 1.
  - op_count wraps from all-ones to 0.
- No overlap: a new command can be accepted no earlier than the cycle after the response handshake. Legal-op throughput is one op per SETTLE_CYCLES+2 cycles.
- cmd_* is ignored outside IDLE. cmd_valid may drop without acceptance.
- rsp_ready outside DONE has no effect.
- alu_* keep their last legal values after completion until the next legal accept.
- SLT: the result appears in rsp_f[0] only, with bits 31:1 = 0 from the ALU. The controller does not reinterpret it.
- No cout output: the ALU's cout equals its overflow.

Test Plan:
- SETTLE_CYCLES=4, cmd x=2 y=3 op=000 accepted at E0 -> alu_x=2/alu_y=3/alu_opcode=000 after E0; rsp_valid high after E0+4; rsp_f=5, rsp_zero=0, rsp_err=0. Then x=1 y=7 -> rsp_f=8; op_count=2 after both handshakes.
- SUB x=5 y=5 (op=011) -> rsp_f=0, rsp_zero=1, rsp_overflow equals the sampled alu_overflow.
- ADD x=32'hFFFFFFFF y=1 -> rsp_f=0, rsp_zero=1, rsp_overflow=1. OR x=32'hF0 y=32'h0F -> rsp_f=32'hFF, rsp_overflow=0.
- Illegal op=101 after a legal ADD -> rsp_valid high one edge after accept; rsp_err=1, rsp_f=0, rsp_zero=0; alu_opcode stays 000; op_count unchanged.
- Backpressure: hold rsp_ready=0 for 10 cycles in DONE while cmd_valid=1 with new data -> rsp_* stable, cmd_ready=0, no accept; the new command is accepted the cycle after rsp_ready=1.
- Pulse rst_n low mid-WAIT (counter=2) -> immediately rsp_valid=0, alu_*=0, op_count=0, state IDLE; the next command completes normally with latency SETTLE_CYCLES.
